// File: rtl/display_pkg.sv
// Shared constants, FSM state type and BCD/segment helpers for result_display.
package display_pkg;

   localparam int DIGITS = 4;
   localparam int BCD_W  = 4 * DIGITS;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (res[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = res[4*i +: 4] + 4'd3;
         end else begin
            res[4*i +: 4] = res[4*i +: 4];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one shift per cycle, DATA_W cycles.
module bin2bcd_serial
   import display_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] bin,
   output logic              done,
   output logic [BCD_W-1:0]  bcd
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] bin_r;
   logic [BCD_W-1:0]  bcd_r;
   logic [BCD_W-1:0]  adj_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              run_r;
   logic              done_r;

   // nibble correction applied to the current BCD value
   always_comb begin
      adj_s = bcd_adjust(bcd_r);
   end

   // load / shift / finish sequencing; abort drops the conversion silently
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_r  <= '0;
         bcd_r  <= '0;
         cnt_r  <= '0;
         run_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (abort) begin
            run_r <= 1'b0;
            cnt_r <= '0;
         end else if (start) begin
            bin_r <= bin;
            bcd_r <= '0;
            cnt_r <= '0;
            run_r <= 1'b1;
         end else if (run_r) begin
            bcd_r <= {adj_s[BCD_W-2:0], bin_r[DATA_W-1]};
            bin_r <= {bin_r[DATA_W-2:0], 1'b0};
            if (cnt_r == CNT_W'(DATA_W - 1)) begin
               run_r  <= 1'b0;
               done_r <= 1'b1;
            end else begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end
      end
   end

   assign done = done_r;
   assign bcd  = bcd_r;

endmodule

// File: rtl/result_display.sv
// Result display back-end: button select, serial BCD conversion, 7-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module result_display
   import display_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              result_valid,
   input  logic [DATA_W-1:0] c00,
   input  logic [DATA_W-1:0] c01,
   input  logic [DATA_W-1:0] c10,
   input  logic [DATA_W-1:0] c11,
   input  logic              up_clean,
   input  logic              left_clean,
   input  logic              right_clean,
   input  logic              down_clean,
   output logic              busy,
   output logic              conv_done,
   output logic [3:0]        anode,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              d,
   output logic              e,
   output logic              f,
   output logic              g,
   output logic              dp
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);

   state_t            state_r;
   logic [3:0]        btn_r;
   logic [3:0]        btn_d_r;
   logic [3:0]        rise_s;
   logic              accept_s;
   logic [DATA_W-1:0] sel_s;
   logic              bcd_done_s;
   logic [BCD_W-1:0]  bcd_s;
   logic [BCD_W-1:0]  disp_r;
   logic              shown_r;
   logic [REF_W-1:0]  scan_cnt_r;
   logic [IDX_W-1:0]  idx_r;
   logic [IDX_W-1:0]  idx_next_s;
   logic              scan_wrap_s;
   logic              digit_blank_s;
   logic [6:0]        seg_s;

   // two-stage edge detect keeps input-to-FSM timing fully registered
   always_comb begin
      rise_s   = btn_r & ~btn_d_r;
      accept_s = result_valid && (state_r == IDLE) && (|rise_s);
   end

   // priority up > left > right > down
   always_comb begin
      if (rise_s[0]) begin
         sel_s = c00;
      end else if (rise_s[1]) begin
         sel_s = c01;
      end else if (rise_s[2]) begin
         sel_s = c10;
      end else begin
         sel_s = c11;
      end
   end

   bin2bcd_serial #(.DATA_W(DATA_W)) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (accept_s),
      .abort (~result_valid),
      .bin   (sel_s),
      .done  (bcd_done_s),
      .bcd   (bcd_s)
   );

   // control FSM with registered busy/conv_done and display latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         btn_r     <= 4'b0000;
         btn_d_r   <= 4'b0000;
         disp_r    <= '0;
         shown_r   <= 1'b0;
         busy      <= 1'b0;
         conv_done <= 1'b0;
      end else begin
         btn_r     <= {down_clean, right_clean, left_clean, up_clean};
         btn_d_r   <= btn_r;
         conv_done <= 1'b0;
         if (!result_valid) begin
            state_r <= IDLE;
            shown_r <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (accept_s) begin
                     state_r <= LOAD;
                     busy    <= 1'b1;
                  end
               end
               LOAD: begin
                  state_r <= SHIFT;
               end
               SHIFT: begin
                  if (bcd_done_s) begin
                     state_r   <= DONE;
                     conv_done <= 1'b1;
                     disp_r    <= bcd_s;
                     shown_r   <= 1'b1;
                  end
               end
               DONE: begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
               default: begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   // scan position for the coming cycle
   always_comb begin
      scan_wrap_s = (scan_cnt_r == REF_W'(REFRESH_DIV - 1));
      if (scan_wrap_s) begin
         idx_next_s = idx_r + IDX_W'(1);
      end else begin
         idx_next_s = idx_r;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] lead_blank_s;

   // a digit is a leading zero when it and every digit above it are zero
   always_comb begin
      lead_blank_s[3] = (disp_r[15:12] == 4'd0);
      lead_blank_s[2] = lead_blank_s[3] && (disp_r[11:8] == 4'd0);
      lead_blank_s[1] = lead_blank_s[2] && (disp_r[7:4] == 4'd0);
      lead_blank_s[0] = 1'b0;
      digit_blank_s   = lead_blank_s[idx_next_s];
   end
`else
   assign digit_blank_s = 1'b0;
`endif

   // segment pattern for the digit about to be lit
   always_comb begin
      if (!shown_r || digit_blank_s) begin
         seg_s = SEG_BLANK;
      end else begin
         seg_s = seg_decode(disp_r[4*idx_next_s +: 4]);
      end
   end

   // scan counter, registered anodes and segments
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_r          <= '0;
         idx_r               <= '0;
         anode               <= 4'b1110;
         {a, b, c, d, e, f, g} <= SEG_BLANK;
      end else begin
         if (scan_wrap_s) begin
            scan_cnt_r <= '0;
         end else begin
            scan_cnt_r <= scan_cnt_r + REF_W'(1);
         end
         idx_r               <= idx_next_s;
         anode               <= ~(4'b0001 << idx_next_s);
         {a, b, c, d, e, f, g} <= seg_s;
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display (DATA_W=8, REFRESH_DIV=4).
module tb_result_display;

   localparam int DW = 8;
   localparam int RD = 4;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] SZ = SB;
`else
   localparam logic [6:0] SZ = S0;
`endif

   logic clk = 1'b0;
   logic rst, result_valid;
   logic [DW-1:0] c00, c01, c10, c11;
   logic up_clean, left_clean, right_clean, down_clean;
   logic busy, conv_done, a, b, c, d, e, f, g, dp;
   logic [3:0] anode;

   int checks = 0;
   int errors = 0;
   int first_busy, done_at, ndone, nbusy;

   always #5 clk = ~clk;

   result_display #(.DATA_W(DW), .REFRESH_DIV(RD)) dut (
      .clk(clk), .rst(rst), .result_valid(result_valid),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11),
      .up_clean(up_clean), .left_clean(left_clean),
      .right_clean(right_clean), .down_clean(down_clean),
      .busy(busy), .conv_done(conv_done), .anode(anode),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k counts edges from the first one that samples the new input (k=0)
   task automatic observe(input int n);
      first_busy = -1;
      done_at    = -1;
      ndone      = 0;
      nbusy      = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (busy) begin
            nbusy++;
            if (first_busy < 0) first_busy = k;
         end
         if (conv_done) begin
            ndone++;
            if (done_at < 0) done_at = k;
         end
      end
   endtask

   task automatic wait_digit(input int idx, input logic [6:0] exp, input string tag);
      logic [3:0] target;
      logic       found;
      target = ~(4'b0001 << idx);
      found  = 1'b0;
      for (int i = 0; i < 4 * RD + 4 && !found; i++) begin
         if (anode === target) found = 1'b1;
         else tick();
      end
      check({tag, "_slot"}, {31'd0, found}, 32'd1);
      check(tag, {25'd0, a, b, c, d, e, f, g}, {25'd0, exp});
   endtask

   initial begin
      rst = 1'b1; result_valid = 1'b0;
      c00 = 8'd0; c01 = 8'd0; c10 = 8'd0; c11 = 8'd0;
      up_clean = 1'b0; left_clean = 1'b0; right_clean = 1'b0; down_clean = 1'b0;
      repeat (3) tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, conv_done}, 32'd0);
      check("rst_anode", {28'd0, anode}, 32'h0000000e);
      check("rst_seg", {25'd0, a, b, c, d, e, f, g}, {25'd0, SB});
      check("rst_dp", {31'd0, dp}, 32'd1);

      // c01 = 13 via left button
      rst = 1'b0; result_valid = 1'b1;
      c00 = 8'd3; c01 = 8'd13; c10 = 8'd255; c11 = 8'd7;
      repeat (2) tick();
      left_clean = 1'b1;
      observe(20);
      check("t1_busy_start", first_busy, 32'd1);
      check("t1_done_cycle", done_at, 32'd10);
      check("t1_done_count", ndone, 32'd1);
      check("t1_busy_end", {31'd0, busy}, 32'd0);
      wait_digit(0, S3, "t1_d0");
      wait_digit(1, S1, "t1_d1");
      wait_digit(2, SZ, "t1_d2");
      wait_digit(3, SZ, "t1_d3");
      left_clean = 1'b0;
      repeat (3) tick();

      // up and down together: up wins, c00 = 3
      up_clean = 1'b1; down_clean = 1'b1;
      observe(25);
      check("t2_done_count", ndone, 32'd1);
      wait_digit(0, S3, "t2_d0");
      wait_digit(1, SZ, "t2_d1");
      up_clean = 1'b0; down_clean = 1'b0;
      repeat (3) tick();

      // result_valid low: edge dropped, display blank
      result_valid = 1'b0;
      repeat (2) tick();
      right_clean = 1'b1;
      observe(15);
      check("t3_busy_count", nbusy, 32'd0);
      check("t3_done_count", ndone, 32'd0);
      wait_digit(0, SB, "t3_d0");
      wait_digit(1, SB, "t3_d1");
      right_clean = 1'b0;
      repeat (3) tick();
      result_valid = 1'b1;
      repeat (3) tick();

      // c10 = 255, second right edge while busy is ignored
      right_clean = 1'b1;
      first_busy = -1; done_at = -1; ndone = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (conv_done) begin
            ndone++;
            if (done_at < 0) done_at = k;
         end
         if (k == 3) right_clean = 1'b0;
         if (k == 5) right_clean = 1'b1;
      end
      check("t4_done_cycle", done_at, 32'd10);
      check("t4_done_count", ndone, 32'd1);
      wait_digit(0, S5, "t4_d0");
      wait_digit(1, S5, "t4_d1");
      wait_digit(2, S2, "t4_d2");
      wait_digit(3, SZ, "t4_d3");
      right_clean = 1'b0;
      repeat (3) tick();

      // reset sampled at cycle 5 of a conversion, then anode scan from reset
      up_clean = 1'b1;
      repeat (5) tick();
      check("t5_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1; up_clean = 1'b0;
      tick();
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_done", {31'd0, conv_done}, 32'd0);
      check("t5_anode", {28'd0, anode}, 32'h0000000e);
      check("t5_seg", {25'd0, a, b, c, d, e, f, g}, {25'd0, SB});
      rst = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 16; k++) begin
         logic [3:0] exp_an;
         tick();
         exp_an = ~(4'b0001 << ((k / RD) % 4));
         check($sformatf("t6_anode_%0d", k), {28'd0, anode}, {28'd0, exp_an});
         if (conv_done) ndone++;
      end
      check("t5_no_done", ndone, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_display.md
# result_display

Display back-end of the matrix accumulator. Once the FSM has finished, a debounced direction button selects one of the four accumulated result entries C00, C01, C10 and C11. The block converts the selected entry from binary to BCD with a serial double-dabble, then time-multiplexes the four BCD digits onto the active-low 7-segment display. It sits directly downstream of the accumulator FSM and the button debouncers, and drives the board display pins.

## Interface
- DATA_W, 8: width of each result entry; legal range 4..13, so every value fits in 4 decimal digits.
- REFRESH_DIV, 100000: clock cycles each digit stays lit; minimum 2.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; this is the debounced reset.
- result_valid  in  1  level; the FSM has finished and c00..c11 are stable.
- c00, c01, c10, c11  in  DATA_W each  result entries.
- up_clean, left_clean, right_clean, down_clean  in  1 each  debounced button levels; they select c00, c01, c10 and c11 respectively.
- busy  out  1  a conversion is in progress.
- conv_done  out  1  one-cycle pulse: the new value has been latched for display.
- anode  out  4  digit enables, active-low; bit 0 is the rightmost digit.
- a, b, c, d, e, f, g  out  1 each  segment drives, active-low.
- dp  out  1  decimal point, active-low; held high (off) at all times.

## Operation
- Edge detection:
  - The block registers each button level and acts only on a rising edge.
  - If several buttons rise in the same cycle, priority is up > left > right > down.
- A rising edge is accepted only when result_valid=1 and the FSM is in IDLE. Any other edge is dropped and is not queued.
- FSM states and transitions:
  - IDLE → LOAD on an accepted edge. LOAD captures the selected entry and clears the BCD register.
  - SHIFT runs for exactly DATA_W cycles. Each cycle, every BCD nibble ≥5 gets +3, then the {BCD, binary} pair shifts left by 1.
  - DONE lasts one cycle: conv_done=1, the 16-bit BCD result is copied into the display register, and the block sets shown=1. The FSM then returns to IDLE.
- busy=1 in LOAD, SHIFT and DONE.
- Falling result_valid, in any state:
  - the FSM returns to IDLE;
  - shown=0 and the display blanks;
  - no conv_done is issued for an aborted conversion.
- Display scan:
  - A counter runs from 0 to REFRESH_DIV-1. When it wraps, the digit index advances 0→1→2→3→0.
  - anode = ~(1 << index).
  - Segments come from the display-register nibble selected by index.
  - When shown=0, or the digit is blanked, all segments are 1.
- Segment codes, listed as {a..g} for the digits 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Reset:
  - The FSM goes to IDLE and shown=0.
  - The display register, BCD register and edge registers are cleared.
  - The scan counter is 0 and the index is 0.
  - Output reset values: busy=0, conv_done=0, anode=4'b1110, a..g=1, dp=1.
  - A reset during SHIFT aborts the conversion with no conv_done.

## Timing
- Cycle 0 is the clock edge that first samples the button high.
- LOAD occupies cycle 1, SHIFT occupies cycles 2..DATA_W+1, and conv_done is high in cycle DATA_W+2. With the default DATA_W this is cycle 10.
- Segments and anodes are registered. A new value appears on the next scan slot after conv_done, at most REFRESH_DIV cycles later.
- Every output is registered. There are no combinational paths from inputs to outputs.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: any digit more significant than the highest non-zero digit is blanked (all segments 1). Digit 0 is never blanked, so the value 0 shows a single "0".
  - Undefined: all four digits show, including leading zeros (13 shows "0013").

## Structure
- Package display_pkg holds:
  - the SEG_0..SEG_9 and SEG_BLANK 7-bit constants;
  - the FSM state enum {IDLE, LOAD, SHIFT, DONE};
  - the DIGITS=4 constant.
- Sub-module bin2bcd_serial holds the double-dabble datapath plus its shift counter, with a start/done handshake. result_display owns button selection, the scan counter and segment decode.

## Test plan
- c01=13, result_valid=1, left_clean rises → conv_done at cycle 10.
  - Digit 0 scan slot: anode=1110, {a..g}=0000110 ("3").
  - Digit 1 scan slot: anode=1101, {a..g}=1001111 ("1").
  - Digits 2 and 3: blank when LEADING_ZERO_BLANK_EN is defined, "0" (0000001) when it is undefined.
- c00=3, c11=7, up_clean and down_clean rise in the same cycle → c00 is converted (digit 0 shows "3"); exactly one conv_done.
- result_valid=0, right_clean rises → no busy, no conv_done, display stays blank.
- c10=255 with DATA_W=8 → digits show 2, 5, 5. Then right_clean rises again during busy → the edge is ignored and only one conv_done occurs.
- Reset asserted during SHIFT at cycle 5 → no conv_done; next cycle busy=0 and anode=1110 with all segments 1.
- REFRESH_DIV=4, rst released → anode sequence is 1110 for 4 cycles, then 1101, 1011, 0111, and wraps back to 1110.
